// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage, the later-stage forwarding sources and the ID/EX pipeline register.
// The master is the surrounding pipeline (or testbench). The slave is id_ex_stage.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          flush;
  logic          id_valid;
  logic [3:0]    id_aluctr;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd_sel;
  logic [DW-1:0] id_rdata_a;
  logic [DW-1:0] id_rdata_b;
  logic [15:0]   id_imm;
  logic          id_alusrc;
  logic          id_extop;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_memwrite;
  logic          id_memtoreg;

  logic          exmem_regwrite;
  logic [RW-1:0] exmem_rd;
  logic [DW-1:0] exmem_result;
  logic          memwb_regwrite;
  logic [RW-1:0] memwb_rd;
  logic [DW-1:0] memwb_result;

  logic          stall;
  logic [3:0]    ALUctr;
  logic [DW-1:0] busA;
  logic [DW-1:0] busB;
  logic [DW-1:0] ex_store_data;
  logic          ex_valid;
  logic [RW-1:0] ex_dst;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_memtoreg;

  modport master (
    output flush, id_valid, id_aluctr, id_rs, id_rt, id_rd_sel, id_rdata_a, id_rdata_b,
           id_imm, id_alusrc, id_extop, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    input  stall, ALUctr, busA, busB, ex_store_data, ex_valid, ex_dst,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );

  modport slave (
    input  flush, id_valid, id_aluctr, id_rs, id_rt, id_rd_sel, id_rdata_a, id_rdata_b,
           id_imm, id_alusrc, id_extop, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result, memwb_regwrite, memwb_rd, memwb_result,
    output stall, ALUctr, busA, busB, ex_store_data, ex_valid, ex_dst,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS core. It provides operand forwarding from EX/MEM and MEM/WB,
// detects load-use hazards, and inserts a bubble on a stall or on a flush from a taken branch or jump.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_AND = 4'b0111,
    ALU_LUI = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctl_t;

  logic          valid_q, valid_d;
  ctl_t          ctl_q, ctl_d;
  logic [3:0]    aluctr_q, aluctr_d;
  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          alusrc_q, alusrc_d;

  logic          stall;
  logic          bubble;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] fwd_rt;

  // A load in EX cannot feed an ID consumer in time, so the consumer waits one cycle.
  assign stall = valid_q & ctl_q.memread & (dst_q != '0) & bus.id_valid &
                 ((bus.id_rs == dst_q) | (bus.id_rt == dst_q));
  assign bubble = bus.flush | stall;

  assign imm_ext = bus.id_extop ? {{(DW-16){bus.id_imm[15]}}, bus.id_imm}
                                : {{(DW-16){1'b0}}, bus.id_imm};

  always_comb begin
    // NOTE: every *_d gets a default first so no path leaves it unassigned (no latch inferred).
    valid_d  = valid_q;
    ctl_d    = ctl_q;
    aluctr_d = aluctr_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    dst_d    = dst_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    alusrc_d = alusrc_q;
    if (bubble) begin
      valid_d  = 1'b0;
      ctl_d    = '0;
      aluctr_d = ALU_ADD;
    end else begin
      valid_d        = bus.id_valid;
      ctl_d.regwrite = bus.id_valid & bus.id_regwrite;
      ctl_d.memread  = bus.id_valid & bus.id_memread;
      ctl_d.memwrite = bus.id_valid & bus.id_memwrite;
      ctl_d.memtoreg = bus.id_valid & bus.id_memtoreg;
      aluctr_d       = bus.id_aluctr;
      rs_d           = bus.id_rs;
      rt_d           = bus.id_rt;
      dst_d          = bus.id_rd_sel;
      a_d            = bus.id_rdata_a;
      b_d            = bus.id_rdata_b;
      imm_d          = imm_ext;
      alusrc_d       = bus.id_alusrc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      ctl_q    <= '0;
      aluctr_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      dst_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      ctl_q    <= ctl_d;
      aluctr_q <= aluctr_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      dst_q    <= dst_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      alusrc_q <= alusrc_d;
    end
  end

  // The younger producer (EX/MEM) wins. Register 0 is never forwarded.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] r,
    input logic [DW-1:0] d,
    input logic          xm_we,
    input logic [RW-1:0] xm_rd,
    input logic [DW-1:0] xm_res,
    input logic          wb_we,
    input logic [RW-1:0] wb_rd,
    input logic [DW-1:0] wb_res
  );
    if (r == '0)                  return d;
    else if (xm_we && xm_rd == r) return xm_res;
    else if (wb_we && wb_rd == r) return wb_res;
    else                          return d;
  endfunction

  assign fwd_rt = fwd(rt_q, b_q, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                      bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);

  assign bus.stall         = stall;
  assign bus.ALUctr        = aluctr_q;
  assign bus.busA          = fwd(rs_q, a_q, bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                                 bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result);
  assign bus.busB          = alusrc_q ? imm_q : fwd_rt;
  assign bus.ex_store_data = fwd_rt;
  assign bus.ex_valid      = valid_q;
  assign bus.ex_dst        = dst_q;
  assign bus.ex_regwrite   = ctl_q.regwrite;
  assign bus.ex_memread    = ctl_q.memread;
  assign bus.ex_memwrite   = ctl_q.memwrite;
  assign bus.ex_memtoreg   = ctl_q.memtoreg;

endmodule
